// File: rtl/softmax_normalize_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : softmax_normalize_16_pkg
// Brief    : Shared sizes and FSM state encoding for the softmax normalize stage.
// Revision : 1.0
// ============================================================================
package softmax_normalize_16_pkg;

    localparam int SOFTMAX_DATA_SIZE  = 16;
    localparam int SOFTMAX_SUM_SIZE   = 20;
    localparam int SOFTMAX_NUM_INPUTS = 10;

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ITER    = 3'd2,
        ST_EMIT    = 3'd3,
        ST_FINISH  = 3'd4
    } softmax_state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/softmax_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : softmax_restoring_divider
// Brief    : Bit-serial restoring divider producing a 0.DATA_SIZE fraction.
// Revision : 1.0
// ============================================================================
module softmax_restoring_divider
    import softmax_normalize_16_pkg::*;
#(
    parameter int DATA_SIZE = SOFTMAX_DATA_SIZE,
    parameter int SUM_SIZE  = SOFTMAX_SUM_SIZE
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 i_start,
    input  logic [DATA_SIZE-1:0] i_dividend,
    input  logic [SUM_SIZE-1:0]  i_divisor,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DATA_SIZE-1:0] o_quotient
);

    localparam int c_iter_w = $clog2(DATA_SIZE);
    localparam logic [c_iter_w-1:0] c_last = c_iter_w'(DATA_SIZE - 1);

    // One spare bit so the doubled remainder never loses its MSB.
    logic [SUM_SIZE:0]    r_rem;
    logic [SUM_SIZE-1:0]  r_div;
    logic [DATA_SIZE-1:0] r_quo;
    logic [c_iter_w-1:0]  r_cnt;
    logic                 r_busy;
    logic                 r_zero;
    logic                 r_sat;

    logic [SUM_SIZE:0]    w_rem_sh;
    logic [SUM_SIZE:0]    w_div_ext;
    logic                 w_ge;

    assign w_rem_sh  = r_rem << 1;
    assign w_div_ext = {1'b0, r_div};
    assign w_ge      = (w_rem_sh >= w_div_ext);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_zero <= 1'b0;
            r_sat  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= (SUM_SIZE + 1)'(i_dividend);
            r_div  <= i_divisor;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_zero <= (i_divisor == '0);
            r_sat  <= (SUM_SIZE'(i_dividend) == i_divisor);
        end else if (r_busy) begin
            r_rem <= w_ge ? (w_rem_sh - w_div_ext) : w_rem_sh;
            r_quo <= {r_quo[DATA_SIZE-2:0], w_ge};
            r_cnt <= r_cnt + c_iter_w'(1);
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Done flags the cycle of the final iteration; the quotient is settled next cycle.
    assign o_busy     = r_busy;
    assign o_done     = r_busy && (r_cnt == c_last);
    // An empty sum wins over saturation, since 0 == 0 would otherwise read as a full share.
    assign o_quotient = r_zero ? '0 :
                        r_sat  ? '1 : r_quo;

endmodule
`default_nettype wire

// File: rtl/softmax_normalize_16.sv
`default_nettype none
// ============================================================================
// Module   : softmax_normalize_16
// Brief    : Buffers one frame of exp values, then emits each divided by the frame sum.
// Revision : 1.0
// ============================================================================
module softmax_normalize_16
    import softmax_normalize_16_pkg::*;
#(
    parameter int DATA_SIZE  = SOFTMAX_DATA_SIZE,
    parameter int NUM_INPUTS = SOFTMAX_NUM_INPUTS,
    parameter int SUM_SIZE   = SOFTMAX_SUM_SIZE
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [DATA_SIZE-1:0] exp_data_i,
    input  logic                 exp_data_valid_i,
    input  logic                 exp_done_i,
    output logic [DATA_SIZE-1:0] softmax_data_o,
    output logic                 softmax_data_valid_o,
    output logic                 softmax_done_o,
    output logic                 overflow_o
);

    localparam int c_cnt_w = cnt_width(NUM_INPUTS);
    localparam logic [c_cnt_w-1:0] c_num = c_cnt_w'(NUM_INPUTS);

    softmax_state_t r_state;
    softmax_state_t w_next;

    logic [DATA_SIZE-1:0] r_buf [NUM_INPUTS];
    logic [c_cnt_w-1:0]   r_wr_cnt;
    logic [c_cnt_w-1:0]   r_rd_ptr;
    logic [SUM_SIZE-1:0]  r_sum;
    logic [DATA_SIZE-1:0] r_data;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_collect;
    logic                 w_accept;
    logic                 w_drop;
    logic [c_cnt_w-1:0]   w_rd_ptr_nxt;
    logic                 w_div_start;
    logic                 w_div_busy;
    logic                 w_div_done;
    logic [DATA_SIZE-1:0] w_div_quotient;

    assign w_collect    = (r_state == ST_COLLECT);
    assign w_accept     = w_collect && exp_data_valid_i && (r_wr_cnt < c_num);
    assign w_drop       = w_collect && exp_data_valid_i && (r_wr_cnt == c_num);
    assign w_rd_ptr_nxt = r_rd_ptr + c_cnt_w'(1);
    assign w_div_start  = (r_state == ST_LOAD);

    softmax_restoring_divider #(
        .DATA_SIZE (DATA_SIZE),
        .SUM_SIZE  (SUM_SIZE)
    ) u_divider (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .i_start    (w_div_start),
        .i_dividend (r_buf[r_rd_ptr]),
        .i_divisor  (r_sum),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_quotient)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_COLLECT: begin
                // A datum arriving alongside done still belongs to this frame.
                if (exp_done_i) begin
                    w_next = ((r_wr_cnt != '0) || w_accept) ? ST_LOAD : ST_FINISH;
                end
            end
            ST_LOAD:   w_next = ST_ITER;
            ST_ITER: begin
                if (w_div_done || !w_div_busy) begin
                    w_next = ST_EMIT;
                end
            end
            ST_EMIT:   w_next = (w_rd_ptr_nxt == r_wr_cnt) ? ST_FINISH : ST_LOAD;
            ST_FINISH: w_next = ST_FINISH;
            default:   w_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state  <= ST_COLLECT;
            r_wr_cnt <= '0;
            r_rd_ptr <= '0;
            r_sum    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= 1'b0;
            if (w_accept) begin
                r_sum    <= r_sum + SUM_SIZE'(exp_data_i);
                r_wr_cnt <= r_wr_cnt + c_cnt_w'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (r_state == ST_EMIT) begin
                r_data   <= w_div_quotient;
                r_valid  <= 1'b1;
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (r_state == ST_FINISH) begin
                r_done <= 1'b1;
            end
        end
    end

    // Frame storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock_i) begin
        if (w_accept) begin
            r_buf[r_wr_cnt] <= exp_data_i;
        end
    end

    assign softmax_data_o       = r_data;
    assign softmax_data_valid_o = r_valid;
    assign softmax_done_o       = r_done;
    assign overflow_o           = r_ovf;

endmodule
`default_nettype wire
